tdot_stream: RTL
================

Name: tdot_stream

Overview:
- Valid/ready streaming front/back end for the existing 8-bit three-term DSP dot-product datapath `top`, which computes y = a0*b0 + a1*b1 + a2*b2 + c.
- Accepts operand vectors on a ready/valid input, skews them into the cascaded DSP chain, and tracks in-flight results.
- Captures results into a response FIFO and presents them on a ready/valid output.
- Sequences datapath reset on every reset assertion, re-armable at any time.

Parameters:
- DP_LATENCY, 5, cycles from a0/b0/c presentation to y valid at the datapath output.
- DEPTH, 8, response FIFO entries; must be >= DP_LATENCY+2 for full throughput; legal range 1..16.
- RST_CYCLES, 3, cycles the datapath sync reset is held high after block reset release.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset; one clock domain only
- in_valid  in  1  operand vector valid
- in_ready  out  1  block accepts vector this cycle
- a0, a1, a2  in  8 each  operand A terms
- b0, b1, b2  in  8 each  operand B terms
- c  in  8  addend
- out_valid  out  1  result at FIFO head valid
- out_ready  in  1  consumer takes result
- y  out  8  result, low 8 bits of the sum
- busy  out  1  high while any result is in flight or buffered, or while in INIT

Behaviour:
- Reset (async assert): all outputs return to 0 immediately.
  - state=INIT, rst counter=0, valid pipe cleared, FIFO pointers and count 0, occupancy 0.
  - Datapath reset dp_rst=1; dp en is tied 1.
- FSM INIT: dp_rst=1 and in_ready=0.
  - The counter increments each cycle after reset release.
  - When the counter reaches RST_CYCLES-1, go to RUN the next cycle; dp_rst drops to 0 in RUN.
- FSM RUN: normal operation. Only async reset returns the FSM to INIT, and reset mid-stream discards all in-flight and buffered results.
- Accept: accept = in_valid & in_ready.
  - in_ready = RUN & (occupancy < DEPTH), where occupancy = in-flight count + FIFO count.
  - This credit rule guarantees that every launched result has a FIFO slot, so the datapath never stalls.
- Skew: on the accept cycle t, a0/b0/c drive the datapath directly.
  - a1/b1 pass through 1 register stage and reach the datapath at t+1.
  - a2/b2 pass through 2 register stages and reach it at t+2.
  - Skew registers are free-running. When accept=0 they load zeros; the resulting garbage is never marked valid.
- Valid pipe: a DP_LATENCY-deep shift register loads accept at its input.
  - The tap at the end of the shift register marks y_dp valid at cycle t+DP_LATENCY.
  - That cycle's edge pushes y_dp into the FIFO.
- Output: out_valid = FIFO count != 0, and y = FIFO head.
  - Results pop on out_valid & out_ready. Order is strictly FIFO.
  - First result appears at out_valid in cycle t+DP_LATENCY+1 (6 cycles with defaults).
- Occupancy update:
  - +1 on accept, -1 on pop; accept and pop in the same cycle leave it unchanged.
  - FIFO push and pop in the same cycle leave the count unchanged. This is legal when the FIFO is full, and at empty only via push.
- Arithmetic: unsigned, modulo 2^8 (P[7:0]). No saturation and no overflow flag.
- busy = INIT | (occupancy != 0).
- Full throughput: one accept per cycle is sustained indefinitely while out_ready=1.
- Backpressure: when out_ready=0, in_ready drops once occupancy reaches DEPTH and rises on the cycle after a pop.

Decomposition:
- Package tdot_pkg holds:
  - DATA_W=8, DP_LATENCY=5, RST_CYCLES=3
  - state enum {INIT, RUN}
  - an operand-vector struct (a0..a2, b0..b2, c)
- Sub-module tdot_rsp_fifo: synchronous FIFO, DEPTH x 8.
  - Ports: push, pop, din, dout, count, with async reset.
  - Show-ahead head (dout valid whenever count != 0).
- Top level contains the FSM, skew registers, valid pipe, occupancy counter, and the `top` instance.

Test Plan:
- Reset release, in_valid=1 held → in_ready=0 for 3 cycles, dp_rst=1 during them; in_ready=1 in the 4th cycle; busy=1 throughout INIT.
- Single vector a=(1,2,3), b=(4,5,6), c=7 accepted at cycle t → out_valid=1, y=39 (0x27) at t+6; pop, then out_valid=0 and busy=0.
- Overflow vector: all a/b terms=255, c=255 → y=2 (195330 mod 256).
- Back-to-back stream of 20 random vectors, out_ready=1 → one accept per cycle with no in_ready drop; outputs match the reference model in order.
- out_ready=0 while streaming → exactly 8 accepts and then in_ready=0; assert out_ready for 1 cycle → one pop, and in_ready=1 in the following cycle for exactly 1 accept.
- Assert reset with 3 in flight and 4 buffered → out_valid=0 and busy=0 immediately; the full INIT sequence repeats; the next vector's result is correct with no stale data.

Source files
------------

// File: rtl/tdot_pkg.sv
// tdot_pkg: shared width, timing constants, FSM state and operand types for the streaming dot-product wrapper
package tdot_pkg;
  localparam int DATA_W = 8;
  localparam int DP_LATENCY = 5;
  localparam int RST_CYCLES = 3;
  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] a0, a1, a2, b0, b1, b2, c;
  } vec_t;
  typedef struct packed {
    logic [DATA_W-1:0] a, b;
  } term_t;
endpackage

// File: rtl/tdot_rsp_fifo.sv
// tdot_rsp_fifo: show-ahead sync FIFO, DEPTH x DATA_W; push_i/din_i write, pop_i drops head, dout_o head (0 when empty), count_o entries; async reset
module tdot_rsp_fifo import tdot_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          din_i,
  output logic [DATA_W-1:0]          dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_d = push_i ? (wr_q == LAST ? '0 : wr_q + AW'(1)) : wr_q;
    rd_d = pop_i ? (rd_q == LAST ? '0 : rd_q + AW'(1)) : rd_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  assign dout_o = count_q != '0 ? mem_q[rd_q] : '0;
  assign count_o = count_q;
endmodule

// File: rtl/top.sv
// top: cascaded 3-term DSP dot-product y = a0*b0 + a1*b1 + a2*b2 + c (mod 2^8); a1/b1 and a2/b2 arrive 1 and 2 cycles after a0/b0/c; y 5 cycles after a0/b0/c; sync rst, clock enable en
module top import tdot_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] b2,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] y
);
  logic [DATA_W-1:0] a0_q, b0_q, c_q, a1_q, b1_q, a2_q, b2_q, p0_q, p1_q, p2_q, y_q;
  always_ff @(posedge clk)
    if (rst) begin
      {a0_q, b0_q, c_q, a1_q, b1_q, a2_q, b2_q} <= '0;
      {p0_q, p1_q, p2_q, y_q} <= '0;
    end else if (en) begin
      {a0_q, b0_q, c_q} <= {a0, b0, c};
      {a1_q, b1_q} <= {a1, b1};
      {a2_q, b2_q} <= {a2, b2};
      p0_q <= a0_q * b0_q + c_q;
      p1_q <= p0_q + a1_q * b1_q;
      p2_q <= p1_q + a2_q * b2_q;
      y_q <= p2_q;
    end
  assign y = y_q;
endmodule

// File: rtl/tdot_stream.sv
// tdot_stream: ready/valid wrapper around the dot-product datapath; in_valid/in_ready + a0..c in, out_valid/out_ready + y out, busy while INIT or results in flight/buffered
module tdot_stream import tdot_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] b2,
  input  logic [DATA_W-1:0] c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic              busy
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [3:0] CNT_LAST = 4'(RST_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [OW-1:0] occ_q, occ_d, fifo_count;
  logic [DP_LATENCY-1:0] vld_q, vld_d;
  term_t s1_q, s1_d, s2a_q, s2a_d, s2b_q, s2b_d;
  logic accept, pop, dp_rst;
  logic [DATA_W-1:0] y_dp;
  // occupancy counts launched-but-unpopped results, so a credit here always guarantees a FIFO slot
  assign in_ready = state_q == RUN && occ_q < DEPTH_C;
  assign accept = in_valid & in_ready;
  assign out_valid = fifo_count != '0;
  assign pop = out_valid & out_ready;
  assign dp_rst = state_q == INIT;
  assign busy = !reset && (state_q == INIT || occ_q != '0);
  always_comb begin
    state_d = (state_q == INIT && cnt_q == CNT_LAST) ? RUN : state_q;
    cnt_d = state_q == INIT ? cnt_q + 4'd1 : cnt_q;
    s1_d = accept ? {a1, b1} : '0;
    s2a_d = accept ? {a2, b2} : '0;
    s2b_d = s2a_q;
    vld_d = {vld_q[DP_LATENCY-2:0], accept};
    occ_d = occ_q + OW'(accept) - OW'(pop);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= INIT;
      cnt_q <= '0;
      vld_q <= '0;
      occ_q <= '0;
      s1_q <= '0;
      s2a_q <= '0;
      s2b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      occ_q <= occ_d;
      s1_q <= s1_d;
      s2a_q <= s2a_d;
      s2b_q <= s2b_d;
    end
  top u_dp (
    .clk(clk), .rst(dp_rst), .en(1'b1),
    .a0(a0), .b0(b0), .c(c),
    .a1(s1_q.a), .b1(s1_q.b),
    .a2(s2b_q.a), .b2(s2b_q.b),
    .y(y_dp)
  );
  tdot_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset),
    .push_i(vld_q[DP_LATENCY-1]), .pop_i(pop),
    .din_i(y_dp), .dout_o(y), .count_o(fifo_count)
  );
endmodule
